mem_wb_skid: RTL

MEM_WB_SKID -- requirements
Module: mem_wb_skid

---
 rtl/mem_wb_skid.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register with a one-entry skid buffer.
// mem_ready is registered, so there is no combinational path from wb_ready to mem_ready.
module mem_wb_skid #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg_waddr,
    input  logic              mem_reg_we,
    input  logic [DATA_W-1:0] mem_reg_wdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_reg_waddr,
    output logic              wb_reg_we,
    output logic [DATA_W-1:0] wb_reg_wdata,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and the holder keeps its payload stable until it transfers.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              mem_ready_q;
    logic [ADDR_W-1:0] out_addr_q, skid_addr_q;
    logic              out_we_q, skid_we_q;
    logic [DATA_W-1:0] out_data_q, skid_data_q;
    logic [CNT_W-1:0]  retire_cnt_q;

    logic accept;
    logic deliver;
    logic out_valid;
    logic capture_we;
    logic load_out_mem;
    logic load_out_skid;
    logic load_skid;

    assign out_valid  = (state_q != EMPTY);
    assign accept     = mem_valid && mem_ready_q;
    assign deliver    = out_valid && wb_ready;
    // Writes to x0 are architecturally dead; drop the enable at capture time.
    assign capture_we = mem_reg_we && (mem_reg_waddr != '0);

    always_comb begin
        state_d       = state_q;
        load_out_mem  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_out_mem = 1'b1;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    load_out_mem = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deliver) begin
                    state_d       = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d       = EMPTY;
            load_out_mem  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            mem_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr_q  <= '0;
            out_we_q    <= 1'b0;
            out_data_q  <= '0;
            skid_addr_q <= '0;
            skid_we_q   <= 1'b0;
            skid_data_q <= '0;
        end else begin
            if (load_out_mem) begin
                out_addr_q <= mem_reg_waddr;
                out_we_q   <= capture_we;
                out_data_q <= mem_reg_wdata;
            end else if (load_out_skid) begin
                out_addr_q <= skid_addr_q;
                out_we_q   <= skid_we_q;
                out_data_q <= skid_data_q;
            end
            if (load_skid) begin
                skid_addr_q <= mem_reg_waddr;
                skid_we_q   <= capture_we;
                skid_data_q <= mem_reg_wdata;
            end
        end
    end

    // A deliver in a flush cycle still retires: WB consumed it on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (deliver) begin
            retire_cnt_q <= retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign mem_ready    = mem_ready_q;
    assign wb_valid     = out_valid;
    assign wb_reg_we    = out_valid && out_we_q;
    assign wb_reg_waddr = out_valid ? out_addr_q : '0;
    assign wb_reg_wdata = out_valid ? out_data_q : '0;
    assign retire_cnt   = retire_cnt_q;
    assign dbg_state    = state_q;

endmodule
